// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single write-capable RAM port, with
// round-robin burst limiting; define RAM_ARB_FIXED_PRIO_EN for fixed requester-0 priority.
module ram_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  mask0,
  input  logic [3:0]  mask1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [31:0] ram_a,
  output logic [31:0] ram_di,
  output logic [3:0]  ram_m,
  output logic        ram_we,
  input  logic [31:0] ram_do
);

  // state  | meaning
  // IDLE   | no requester owns the RAM port
  // GRANT0 | requester 0 owns the port while req0 is high
  // GRANT1 | requester 1 owns the port while req1 is high
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] burst_cnt;
  logic       last_served;
  logic       rvalid0_q;
  logic       rvalid1_q;

  assign gnt0 = (state == GRANT0) & req0 & ~reset;
  assign gnt1 = (state == GRANT1) & req1 & ~reset;

  // A read captured just before reset must not surface while reset is high.
  assign rvalid0 = rvalid0_q & ~reset;
  assign rvalid1 = rvalid1_q & ~reset;

  always_comb begin
    ram_a  = '0;
    ram_di = '0;
    ram_m  = '0;
    ram_we = 1'b0;
    if (gnt0) begin
      ram_a  = addr0;
      ram_di = wdata0;
      ram_m  = mask0;
      ram_we = we0;
    end else if (gnt1) begin
      ram_a  = addr1;
      ram_di = wdata1;
      ram_m  = mask1;
      ram_we = we1;
    end
  end

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0)      state_nxt = GRANT0;
        else if (req1) state_nxt = GRANT1;
      end
      GRANT0: begin
        if (req0)      state_nxt = GRANT0;
        else if (req1) state_nxt = GRANT1;
        else           state_nxt = IDLE;
      end
      GRANT1: begin
        if (req0)      state_nxt = GRANT0;
        else if (req1) state_nxt = GRANT1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  logic burst_done;

  // >= together with the saturating counter keeps a long solo run from
  // wrapping past the limit and starving the other requester.
  assign burst_done = (burst_cnt >= BURST_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_served ? GRANT0 : GRANT1;
        else if (req0)    state_nxt = GRANT0;
        else if (req1)    state_nxt = GRANT1;
      end
      GRANT0: begin
        if (req0)      state_nxt = (req1 && burst_done) ? GRANT1 : GRANT0;
        else if (req1) state_nxt = GRANT1;
        else           state_nxt = IDLE;
      end
      GRANT1: begin
        if (req1)      state_nxt = (req0 && burst_done) ? GRANT0 : GRANT1;
        else if (req0) state_nxt = GRANT0;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata       <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        burst_cnt <= '0;
      else if ((gnt0 || gnt1) && burst_cnt != 4'hF)
        burst_cnt <= burst_cnt + 4'd1;
      if (gnt0)
        last_served <= 1'b0;
      else if (gnt1)
        last_served <= 1'b1;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if ((gnt0 && !we0) || (gnt1 && !we1))
        rdata <= ram_do;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, read-data scoreboard,
// directed scenarios for latency, masking, bursts, reset and dropped requests.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  mask0, mask1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, ram_a, ram_di, ram_do;
  logic [3:0]  ram_m;
  logic        ram_we;

  typedef struct {
    int          rid;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [16];

  ram_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mask0(mask0), .mask1(mask1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_a(ram_a), .ram_di(ram_di), .ram_m(ram_m),
    .ram_we(ram_we), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  assign ram_do = mem[ram_a[5:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_m[b]) mem[ram_a[5:2]][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: mutual exclusion, reset blanking, and scoreboard pop on rvalid.
  always @(negedge clk) begin
    chk("mutex", {31'd0, gnt0 & gnt1}, 32'd0);
    if (reset) chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    if (rvalid0 || rvalid1) begin
      if (sbq.size() == 0) begin
        chk("rvalid_unexp", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rvalid_id", {30'd0, rvalid1, rvalid0}, (mon_e.rid == 0) ? 32'd1 : 32'd2);
        chk("rdata", rdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rid, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (rid == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d; mask0 = m;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d; mask1 = m;
    end
  endtask

  // Returns at the negedge where the grant is visible.
  task automatic wait_gnt(input int rid, output int lat, output bit got);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if ((rid == 0) ? gnt0 : gnt1) got = 1;
      else begin
        lat++;
        tick();
      end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input int rid, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    drive(rid, 1'b1, w, a, d, m);
    wait_gnt(rid, lat, got);
    if (got) begin
      chk("latency", lat, exp_lat);
      chk("ram_we", {31'd0, ram_we}, {31'd0, w});
      chk("ram_a", ram_a, a);
      chk("ram_di", ram_di, d);
      chk("ram_m", {28'd0, ram_m}, {28'd0, m});
      if (!w) sbq.push_back('{rid, exp});
    end
    tick();
    drive(rid, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    int  lat;
    bit  got;
    bit  e0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[2] = 32'hDEADBEEF;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    tick();

    // Single read from idle: grant one cycle later, data the cycle after.
    do_access(0, 1'b0, 32'h8, 32'd0, 4'd0, 32'hDEADBEEF, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    chk("rvalid0_low", {31'd0, rvalid0}, 32'd0);
    tick();

    // Masked write then back-to-back read of the same word.
    do_access(1, 1'b1, 32'h4, 32'h11223344, 4'b0101, 32'd0, 1);
    do_access(1, 1'b0, 32'h4, 32'd0, 4'd0, 32'h00220044, 0);
    repeat (3) tick();

    // Both requesters held: alternating runs of MAX_BURST grants.
    drive(0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    drive(1, 1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("burst_idle0", {31'd0, gnt0}, 32'd0);
        chk("burst_idle1", {31'd0, gnt1}, 32'd0);
      end else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        e0 = 1'b1;
`else
        e0 = (((i - 1) / 4) % 2) == 0;
`endif
        chk("burst_gnt0", {31'd0, gnt0}, {31'd0, e0});
        chk("burst_gnt1", {31'd0, gnt1}, {31'd0, ~e0});
        if (e0) sbq.push_back('{0, 32'hDEADBEEF});
      end
      tick();
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) tick();

    // Reset during a requester-1 write burst; req1 stays high across it.
    drive(1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
    wait_gnt(1, lat, got);
    tick();
    @(negedge clk);
    chk("wburst_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, ram_we}, 32'd0);
    chk("rst_mid_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, gnt1}, 32'd0);
    chk("post_rst_rv1", {31'd0, rvalid1}, 32'd0);
    @(negedge clk);
    chk("post_rst_regnt", {31'd0, gnt1}, 32'd1);
    tick();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) tick();

    // Read granted right before reset: no rvalid, rdata cleared, pointer back to 0.
    drive(0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    wait_gnt(0, lat, got);
    tick();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("rst_rd_rv0", {31'd0, rvalid0}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rd_rdata", rdata, 32'd0);
    chk("rst_rd_rv0b", {31'd0, rvalid0}, 32'd0);
    tick();
    drive(0, 1'b1, 1'b1, 32'h30, 32'h01010101, 4'hF);
    drive(1, 1'b1, 1'b1, 32'h30, 32'h02020202, 4'hF);
    @(negedge clk);
    chk("rr_idle0", {31'd0, gnt0}, 32'd0);
    @(negedge clk);
    chk("rr_first0", {31'd0, gnt0}, 32'd1);
    chk("rr_first1", {31'd0, gnt1}, 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) tick();

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Requester 0 preempts an active requester-1 burst.
    drive(1, 1'b1, 1'b1, 32'h20, 32'h0F0F0F0F, 4'hF);
    wait_gnt(1, lat, got);
    tick();
    tick();
    drive(0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    @(negedge clk);
    chk("pre_k_gnt1", {31'd0, gnt1}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("preempt_gnt0", {31'd0, gnt0}, 32'd1);
      chk("preempt_gnt1", {31'd0, gnt1}, 32'd0);
      sbq.push_back('{0, 32'hDEADBEEF});
    end
    tick();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("preempt_end0", {31'd0, gnt0}, 32'd0);
    tick();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) tick();
`else
    // A one-cycle req0 pulse during a requester-1 burst never reaches the RAM.
    drive(1, 1'b1, 1'b1, 32'h20, 32'h0F0F0F0F, 4'hF);
    wait_gnt(1, lat, got);
    tick();
    drive(0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    @(negedge clk);
    chk("pulse_gnt0", {31'd0, gnt0}, 32'd0);
    chk("pulse_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pulse_after_gnt0", {31'd0, gnt0}, 32'd0);
      tick();
    end
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) tick();
`endif

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
